// File: rtl/output_bias_argmax.sv
// ---------------------------------------------------------------------------
// output_bias_argmax
//
// Final stage of the output layer. Accepts one raw Q16.16 MAC accumulator per
// output neuron, in order. It adds that neuron's Q8.8 bias from the bias ROM,
// then rescales and saturates the sum to a Q8.8 logit. Each logit is streamed
// out with a latency of one cycle. After the last neuron of a frame it reports
// the argmax class and its logit.
//
// Ports
//   clk, rst_n     : system clock, asynchronous active-low reset
//   start          : one-cycle frame start pulse (honoured in IDLE only)
//   acc_valid/ready: upstream accumulator handshake
//   acc_data       : signed Q16.16 accumulator for the current neuron
//   bias_addr      : bias ROM address (current neuron index, registered)
//   bias_data      : signed Q8.8 bias, combinational response to bias_addr
//   logit_valid    : one-cycle pulse per produced logit
//   logit_idx      : neuron index of logit_data
//   logit_data     : signed Q8.8 biased, saturated logit
//   class_valid    : one-cycle pulse, frame result valid
//   class_out      : argmax neuron index
//   max_logit      : logit value at class_out
//   busy           : high while a frame is in RUN or DONE
// ---------------------------------------------------------------------------
module output_bias_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 32,
  parameter int SHIFT       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              acc_valid,
  input  logic [ACC_W-1:0]  acc_data,
  output logic              acc_ready,
  output logic [ADDR_W-1:0] bias_addr,
  input  logic [DATA_W-1:0] bias_data,
  output logic              logit_valid,
  output logic [ADDR_W-1:0] logit_idx,
  output logic [DATA_W-1:0] logit_data,
  output logic              class_valid,
  output logic [ADDR_W-1:0] class_out,
  output logic [DATA_W-1:0] max_logit,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CLASSES - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  // Saturation bounds expressed at the full sum width.
  localparam logic signed [ACC_W:0] SAT_HI =
    {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_LO =
    {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                    state;
  logic [ADDR_W-1:0]         idx;
  logic signed [DATA_W-1:0]  run_max;
  logic [ADDR_W-1:0]         run_arg;

  logic                      xfer;
  logic signed [ACC_W:0]     sum;
  logic signed [ACC_W:0]     shifted;
  logic signed [DATA_W-1:0]  logit;
  logic                      new_max;

  // Ready depends on state alone, so upstream never sees a path from its own
  // valid back to ready.
  assign acc_ready = (state == RUN);
  assign busy      = (state != IDLE);
  assign bias_addr = idx;
  assign xfer      = acc_valid && acc_ready;

  // NOTE: every variable gets a value before any branch. A path through the
  // block that does not assign a variable would make synthesis infer a latch.
  always_comb begin
    sum     = '0;
    shifted = '0;
    logit   = '0;
    new_max = 1'b0;

    // Both operands are sign-extended to ACC_W+1 bits. The sum therefore
    // cannot wrap before it is saturated.
    sum = $signed({acc_data[ACC_W-1], acc_data})
        + ($signed({{(ACC_W + 1 - DATA_W){bias_data[DATA_W-1]}}, bias_data}) <<< SHIFT);
    // The arithmetic shift truncates toward -inf.
    shifted = sum >>> SHIFT;

    if (shifted > SAT_HI) begin
      logit = MOST_POS;
    end else if (shifted < SAT_LO) begin
      logit = MOST_NEG;
    end else begin
      logit = shifted[DATA_W-1:0];
    end

    // The comparison is strict, so on a tie the earlier (lower) index is kept.
    new_max = (logit > run_max);
  end

  // NOTE: state is written only with non-blocking assignments. Every register
  // therefore samples the values from before the clock edge, whatever order
  // the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      run_max     <= MOST_NEG;
      run_arg     <= '0;
      logit_valid <= 1'b0;
      logit_idx   <= '0;
      logit_data  <= '0;
      class_valid <= 1'b0;
      class_out   <= '0;
      max_logit   <= MOST_NEG;
    end else begin
      logit_valid <= 1'b0;
      class_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            idx     <= '0;
            run_max <= MOST_NEG;
            run_arg <= '0;
          end
        end

        RUN: begin
          if (xfer) begin
            logit_data  <= logit;
            logit_idx   <= idx;
            logit_valid <= 1'b1;

            if (new_max) begin
              run_max <= logit;
              run_arg <= idx;
            end

            if (idx == LAST_IDX) begin
              // The frame result is registered here, so class_valid is high
              // during the DONE cycle. It coincides with the last logit pulse
              // and includes the last neuron.
              state       <= DONE;
              idx         <= '0;
              class_valid <= 1'b1;
              class_out   <= new_max ? idx   : run_arg;
              max_logit   <= new_max ? logit : run_max;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
